// File: rtl/crc16_pkg.sv
// Shared types, widths and bit-reversal helpers for the CRC16 stream engine.
package crc16_pkg;

    localparam int NIB_W = 4;
    localparam int CRC_W = 16;

    localparam logic POLY_1021 = 1'b0;
    localparam logic POLY_8005 = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCEPT, SHIFT, DONE} state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

endpackage

// File: rtl/crc16_1021.sv
// One nibble step of the MSB-first CRC16 with polynomial x^16+x^12+x^5+1.
module crc16_1021
    import crc16_pkg::*;
(
    input  logic [NIB_W-1:0] data_i,
    input  logic [CRC_W-1:0] crc_i,
    output logic [CRC_W-1:0] crc_o
);

    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    logic [CRC_W-1:0] c;

    // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
    always_comb begin
        c = crc_i;
        for (int i = NIB_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data_i[i]) c = {c[CRC_W-2:0], 1'b0} ^ POLY;
            else                        c = {c[CRC_W-2:0], 1'b0};
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc16_8005.sv
// One nibble step of the MSB-first CRC16 with polynomial x^16+x^15+x^2+1.
module crc16_8005
    import crc16_pkg::*;
(
    input  logic [NIB_W-1:0] data_i,
    input  logic [CRC_W-1:0] crc_i,
    output logic [CRC_W-1:0] crc_o
);

    localparam logic [CRC_W-1:0] POLY = 16'h8005;

    logic [CRC_W-1:0] c;

    always_comb begin
        c = crc_i;
        for (int i = NIB_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data_i[i]) c = {c[CRC_W-2:0], 1'b0} ^ POLY;
            else                        c = {c[CRC_W-2:0], 1'b0};
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc16_stream_engine.sv
// Serialises 1-4 byte words into nibbles and iterates the selected CRC16 step,
// applying init, reflection and final XOR around the nibble functions.
module crc16_stream_engine
    import crc16_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        poly_sel_i,
    input  logic [15:0] init_i,
    input  logic        refin_i,
    input  logic        refout_i,
    input  logic [15:0] xorout_i,
    input  logic [31:0] dat_i,
    input  logic [1:0]  len_i,
    input  logic        last_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic [15:0] crc_o,
    output logic        crc_valid_o,
    input  logic        crc_ready_i
);

    state_t      state_q;
    logic [15:0] crc_q;
    logic [15:0] xorout_q;
    logic        poly_q;
    logic        refin_q;
    logic        refout_q;
    logic        last_q;
    logic [31:0] word_q;
    logic [2:0]  cnt_q;

    logic [NIB_W-1:0] nibble;
    logic [CRC_W-1:0] crc_1021;
    logic [CRC_W-1:0] crc_8005;
    logic [CRC_W-1:0] crc_next;
    logic [31:0]      dat_ref;

    // Odd counter values select the high nibble; the current byte always sits in word_q[7:0].
    assign nibble = cnt_q[0] ? word_q[7:4] : word_q[3:0];

    crc16_1021 u_crc16_1021 (
        .data_i (nibble),
        .crc_i  (crc_q),
        .crc_o  (crc_1021)
    );

    crc16_8005 u_crc16_8005 (
        .data_i (nibble),
        .crc_i  (crc_q),
        .crc_o  (crc_8005)
    );

    always_comb begin
        crc_next = crc_1021;
        unique case (poly_q)
            POLY_1021: crc_next = crc_1021;
            POLY_8005: crc_next = crc_8005;
        endcase
    end

    assign dat_ref = {rev8(dat_i[31:24]), rev8(dat_i[23:16]),
                      rev8(dat_i[15:8]),  rev8(dat_i[7:0])};

    // NOTE: only control state and outputs are reset; the datapath registers are
    // always loaded before use, so leaving them unreset keeps the reset tree small.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            crc_valid_o <= 1'b0;
            crc_o       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        crc_q    <= init_i;
                        poly_q   <= poly_sel_i;
                        refin_q  <= refin_i;
                        refout_q <= refout_i;
                        xorout_q <= xorout_i;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b1;
                        state_q  <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (valid_i) begin
                        word_q  <= refin_q ? dat_ref : dat_i;
                        cnt_q   <= {len_i, 1'b1};
                        last_q  <= last_i;
                        ready_o <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc_q <= crc_next;
                    cnt_q <= cnt_q - 3'd1;
                    if (!cnt_q[0]) word_q <= word_q >> 8;
                    if (cnt_q == 3'd0) begin
                        if (last_q) begin
                            crc_o       <= (refout_q ? rev16(crc_next) : crc_next) ^ xorout_q;
                            crc_valid_o <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            ready_o <= 1'b1;
                            state_q <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    if (crc_ready_i) begin
                        crc_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_stream_engine.sv
// Directed bench: "123456789" through several CRC16 catalogue variants, plus timing,
// back-pressure, abort and ignored-input checks.
module tb_crc16_stream_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        poly_sel_i = 1'b0;
    logic [15:0] init_i = '0;
    logic        refin_i = 1'b0;
    logic        refout_i = 1'b0;
    logic [15:0] xorout_i = '0;
    logic [31:0] dat_i = '0;
    logic [1:0]  len_i = '0;
    logic        last_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic [15:0] crc_o;
    logic        crc_valid_o;
    logic        crc_ready_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] words [3];
    logic [1:0]  lens  [3];
    logic        lasts [3];

    crc16_stream_engine dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .poly_sel_i  (poly_sel_i),
        .init_i      (init_i),
        .refin_i     (refin_i),
        .refout_i    (refout_i),
        .xorout_i    (xorout_i),
        .dat_i       (dat_i),
        .len_i       (len_i),
        .last_i      (last_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .crc_o       (crc_o),
        .crc_valid_o (crc_valid_o),
        .crc_ready_i (crc_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx);
        dat_i  = words[idx];
        len_i  = lens[idx];
        last_i = lasts[idx];
    endtask

    // Sends the message, flips the configuration inputs after start, holds the
    // result for `hold` cycles, then consumes it with a simultaneous start pulse.
    task automatic run_msg(input string name, input logic poly, input logic [15:0] init,
                           input logic refin, input logic refout, input logic [15:0] xorout,
                           input logic [15:0] exp, input int hold, input bit pulse,
                           output int lat, output int rdy_cnt);
        int  idx;
        int  n;
        bit  hs;
        bit  got;
        logic [15:0] crc;
        @(negedge clk_i);
        poly_sel_i = poly; init_i = init; refin_i = refin; refout_i = refout; xorout_i = xorout;
        start_i = 1'b1; crc_ready_i = 1'b0;
        idx = 0; set_word(0); valid_i = 1'b1;
        n = 0; hs = 0; got = 0; rdy_cnt = 0; crc = '0;
        while (!got && n < 200) begin
            @(negedge clk_i);
            n++;
            start_i = pulse && (n == 5);
            if (n == 1) begin
                poly_sel_i = ~poly; init_i = ~init; refin_i = ~refin;
                refout_i = ~refout; xorout_i = ~xorout;
            end
            if (hs) begin
                hs = 0;
                idx++;
                if (idx < 3) set_word(idx);
                else valid_i = 1'b0;
            end
            if (ready_o) rdy_cnt++;
            if (crc_valid_o) begin
                got = 1;
                crc = crc_o;
            end else if (ready_o && valid_i) begin
                hs = 1;
            end
        end
        lat = n - 1;
        check({name, " result valid"}, 32'(got), 32'd1);
        check({name, " crc"}, 32'(crc), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({name, " hold crc"}, 32'(crc_o), 32'(exp));
            check({name, " hold valid"}, 32'(crc_valid_o), 32'd1);
        end
        @(negedge clk_i);
        crc_ready_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        crc_ready_i = 1'b0;
        start_i = 1'b0;
        check({name, " valid cleared"}, 32'(crc_valid_o), 32'd0);
        check({name, " idle busy"}, 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check({name, " start at handshake ignored"}, 32'(busy_o), 32'd0);
        check({name, " idle ready"}, 32'(ready_o), 32'd0);
    endtask

    initial begin
        int lat;
        int rdy;
        words[0] = 32'h34333231; lens[0] = 2'd3; lasts[0] = 1'b0;
        words[1] = 32'h38373635; lens[1] = 2'd3; lasts[1] = 1'b0;
        words[2] = 32'h00000039; lens[2] = 2'd0; lasts[2] = 1'b1;

        repeat (3) @(negedge clk_i);
        check("reset ready_o", 32'(ready_o), 32'd0);
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset crc_valid_o", 32'(crc_valid_o), 32'd0);
        check("reset crc_o", 32'(crc_o), 32'd0);
        rst_i = 1'b0;

        valid_i = 1'b1;
        set_word(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("idle valid not accepted", 32'(ready_o), 32'd0);
        end
        check("idle busy", 32'(busy_o), 32'd0);

        run_msg("ccitt", 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h29B1, 5, 1'b0, lat, rdy);
        check("ccitt latency", 32'(lat), 32'd21);
        check("ccitt ready count", 32'(rdy), 32'd3);

        run_msg("xmodem", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h31C3, 0, 1'b1, lat, rdy);
        run_msg("arc", 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hBB3D, 1, 1'b0, lat, rdy);
        run_msg("modbus", 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h4B37, 0, 1'b1, lat, rdy);
        run_msg("x25", 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'h906E, 2, 1'b0, lat, rdy);

        // Abort after the fourth nibble of the first word.
        @(negedge clk_i);
        poly_sel_i = 1'b0; init_i = 16'hFFFF; refin_i = 1'b0; refout_i = 1'b0; xorout_i = 16'h0;
        start_i = 1'b1; set_word(0); valid_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("abort busy before reset", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort busy_o", 32'(busy_o), 32'd0);
        check("abort crc_valid_o", 32'(crc_valid_o), 32'd0);
        check("abort ready_o", 32'(ready_o), 32'd0);
        check("abort crc_o", 32'(crc_o), 32'd0);

        run_msg("ccitt after abort", 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h29B1, 0, 1'b0, lat, rdy);
        check("rerun latency", 32'(lat), 32'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
